md_unit: RTL and testbench
==========================

# md_unit

Iterative multiply/divide unit serving the MIPS MULT/MULTU/DIV/DIVU instructions, alongside the combinational ALU. It accepts two 32-bit operands, an op select and a Sign flag on a single-cycle start handshake. It runs a 32-iteration shift-add multiply or restoring divide, then presents a 64-bit result on HI/LO with a one-cycle done pulse. The datapath stalls on busy until done.

## Interface
- `WIDTH`, default 32: operand width; HI/LO are each WIDTH bits.
- `clk`, input, 1: rising-edge clock. One clock domain.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request. Sampled only in IDLE.
- `op`, input, 1: 0 = multiply, 1 = divide.
- `Sign`, input, 1: 1 = two's-complement operands, 0 = unsigned (same meaning as the ALU's Sign).
- `A`, input, WIDTH: multiplicand, or dividend.
- `B`, input, WIDTH: multiplier, or divisor.
- `busy`, output, 1: operation in progress. New starts are ignored while high.
- `done`, output, 1: one-cycle pulse. HI/LO/div_zero are valid from this cycle on.
- `HI`, output, WIDTH: product upper half, or remainder.
- `LO`, output, WIDTH: product lower half, or quotient.
- `div_zero`, output, 1: last completed divide had B == 0. Cleared by any later completion.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE→RUN on start.
  - RUN→FIX after 32 iterations.
  - FIX→IDLE unconditionally.
- Capture (IDLE, start=1):
  - Latch op and Sign.
  - With Sign=1, latch |A| and |B|, plus neg_q = A[31]^B[31] and neg_r = A[31].
  - With Sign=0, latch raw operands and clear both neg flags.
  - Clear the iteration counter to 0.
- RUN, multiply: per iteration, if the multiplier LSB is set, add the multiplicand to the upper accumulator (33-bit add, carry kept). Then shift the 64-bit {acc, mplr} right by 1.
- RUN, divide: per iteration, shift {rem, quo} left by 1 and trial-subtract the divisor from rem (33-bit).
  - Non-negative difference: keep it and set quo LSB.
  - Negative difference: restore.
- FIX:
  - Multiply: if neg_q, negate the 64-bit product.
  - Divide: if neg_q, negate the quotient; if neg_r, negate the remainder.
  - Write HI/LO, assert done, return to IDLE.
- Divide by zero (B == 0): HI = A (raw input value), LO = 32'hFFFFFFFF, div_zero = 1. No sign fix-up. Latency is unchanged.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, div_zero = 0. This falls out of the abs/negate path and needs no special case.
- HI/LO hold the last result until the next FIX. They are not disturbed during RUN.

## Timing
- Reset values: state IDLE, busy 0, done 0, HI 0, LO 0, div_zero 0, counter 0.
- Latency, with start sampled at edge 0:
  - Edges 1–32: iterations.
  - Edge 33: FIX.
  - done is high for the single cycle after edge 33.
- busy is high after edge 0 through edge 32, low once FIX completes. busy and done are never high together.
- start while busy: ignored. No queuing and no effect on the running operation.
- start in the cycle done is high: accepted, since state is IDLE. The next result follows 33 edges later.
- Operand inputs need only be stable at the start edge.
- Reset mid-operation: immediate return to reset values. The partial result is discarded and no done is issued.
- Throughput: one operation per 34 cycles (33-edge latency plus the IDLE cycle in which the next start is sampled).

## Structure
- Shared package `mips_md_pkg`:
  - op encoding constants (MD_MUL, MD_DIV).
  - state enum (IDLE/RUN/FIX).
  - iteration count constant (32).
- Single module, no sub-modules. Negate/abs helpers are package functions, not instances.

## Test plan
- Unsigned multiply: A=B=0xFFFFFFFF, Sign=0, op=0 → done 33 cycles after start; HI=0xFFFFFFFE, LO=0x00000001.
- Signed multiply: A=0xFFFFFFFD (-3), B=7, Sign=1 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- Signed divide: A=0xFFFFFFF9 (-7), B=2, Sign=1, op=1 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, div_zero=0.
- Divide by zero: A=0x00001234, B=0 → HI=0x00001234, LO=0xFFFFFFFF, div_zero=1. A following 100/7 unsigned gives LO=14, HI=2, div_zero=0.
- Overflow: A=0x80000000, B=0xFFFFFFFF, Sign=1, op=1 → LO=0x80000000, HI=0.
- Handshake and reset:
  - start pulsed at iteration 5 → ignored, result unchanged.
  - reset asserted at iteration 10 → busy/done/HI/LO read 0 immediately.
  - Back-to-back start on the done cycle → second result 33 edges later.

Source files
------------

// File: rtl/mips_md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states, iteration count and the conditional-negate helpers.
package mips_md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = $clog2(MD_ITERS);

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Two's-complement negate when en is set; used both for abs() at capture
  // and for the sign fix-up of the finished result.
  function automatic logic [MD_WIDTH-1:0] f_neg_if(input logic [MD_WIDTH-1:0] x,
                                                   input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*MD_WIDTH-1:0] f_neg_if_dw(input logic [2*MD_WIDTH-1:0] x,
                                                        input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative 32-step shift-add multiplier / restoring divider for MIPS
// MULT/MULTU/DIV/DIVU, with magnitude datapath and a final sign fix-up cycle.
module md_unit
  import mips_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_zero
);

  localparam logic [MD_CNT_W-1:0] LAST_ITER = MD_CNT_W'(MD_ITERS - 1);

  md_state_e r_state;
  md_state_e w_next;

  logic [MD_CNT_W-1:0] r_cnt;
  logic                r_op;
  logic                r_neg_q;
  logic                r_neg_r;
  logic                r_b_zero;
  logic [WIDTH-1:0]    r_raw_a;
  // r_acc: product upper half / remainder; r_lo: multiplier / quotient
  logic [WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]    r_lo;
  logic [WIDTH-1:0]    r_opb;
  logic [WIDTH-1:0]    r_hi_out;
  logic [WIDTH-1:0]    r_lo_out;
  logic                r_div_zero;
  logic                r_done;

  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH:0]      w_mul_acc;
  logic [WIDTH:0]      w_shift;
  logic                w_ge;
  logic [WIDTH-1:0]    w_diff;
  logic [WIDTH-1:0]    w_acc_nxt;
  logic [WIDTH-1:0]    w_lo_nxt;
  logic [2*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]    w_hi_fix;
  logic [WIDTH-1:0]    w_lo_fix;
  logic                w_dz_fix;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == LAST_ITER) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == RUN) || (r_state == FIX);
    done = r_done;
  end

  // ---------------------------------------------------------- datapath
  assign w_abs_a = f_neg_if(A, Sign & A[WIDTH-1]);
  assign w_abs_b = f_neg_if(B, Sign & B[WIDTH-1]);

  // Multiply step: conditional 33-bit add, then shift {acc, mplr} right.
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_opb};
  assign w_mul_acc = r_lo[0] ? w_sum : {1'b0, r_acc};

  // Divide step: shift {rem, quo} left, trial-subtract divisor from rem.
  // When the trial succeeds the true difference is below the divisor, so
  // the low WIDTH bits of the subtraction are exact.
  assign w_shift = {r_acc, r_lo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opb});
  assign w_diff  = w_shift[WIDTH-1:0] - r_opb;

  always_comb begin
    w_acc_nxt = r_acc;
    w_lo_nxt  = r_lo;
    if (r_op == MD_MUL) begin
      w_acc_nxt = w_mul_acc[WIDTH:1];
      w_lo_nxt  = {w_mul_acc[0], r_lo[WIDTH-1:1]};
    end else begin
      w_acc_nxt = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_lo_nxt  = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  assign w_prod = f_neg_if_dw({r_acc, r_lo}, r_neg_q);

  always_comb begin
    w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
    w_dz_fix = 1'b0;
    if (r_op == MD_DIV) begin
      if (r_b_zero) begin
        w_hi_fix = r_raw_a;
        w_lo_fix = '1;
        w_dz_fix = 1'b1;
      end else begin
        w_hi_fix = f_neg_if(r_acc, r_neg_r);
        w_lo_fix = f_neg_if(r_lo, r_neg_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_op       <= MD_MUL;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_raw_a    <= '0;
      r_acc      <= '0;
      r_lo       <= '0;
      r_opb      <= '0;
      r_hi_out   <= '0;
      r_lo_out   <= '0;
      r_div_zero <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt    <= '0;
            r_op     <= op;
            r_neg_q  <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
            r_neg_r  <= Sign & A[WIDTH-1];
            r_b_zero <= (B == '0);
            r_raw_a  <= A;
            r_acc    <= '0;
            if (op == MD_MUL) begin
              r_opb <= w_abs_a;
              r_lo  <= w_abs_b;
            end else begin
              r_opb <= w_abs_b;
              r_lo  <= w_abs_a;
            end
          end
        end
        RUN: begin
          r_acc <= w_acc_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + MD_CNT_W'(1);
        end
        FIX: begin
          r_hi_out   <= w_hi_fix;
          r_lo_out   <= w_lo_fix;
          r_div_zero <= w_dz_fix;
        end
        default: ;
      endcase
    end
  end

  assign HI       = r_hi_out;
  assign LO       = r_lo_out;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_md_unit.sv
// Directed, table-driven bench for md_unit: result vectors plus hand-written
// sequences for start-while-busy, mid-operation reset and back-to-back starts.
module tb_md_unit;
  import mips_md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         op;
  logic         sign;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         dz;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .Sign     (sign),
    .A        (a),
    .B        (b),
    .busy     (busy),
    .done     (done),
    .HI       (hi),
    .LO       (lo),
    .div_zero (dz)
  );

  typedef struct {
    string        name;
    logic         op;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive a request so it is sampled at the next rising edge (edge 0), then
  // scramble the operands to show they only matter at that edge.
  task automatic launch(input logic f_op, input logic f_sign,
                        input logic [W-1:0] f_a, input logic [W-1:0] f_b);
    op    = f_op;
    sign  = f_sign;
    a     = f_a;
    b     = f_b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~f_a;
    b     = f_b ^ 32'h5A5A_A5A5;
  endtask

  // Count edges after edge 0 until done is seen; optionally pulse start
  // (with different operands) after edge glitch_at while the unit is busy.
  task automatic collect(input vec_t v, input int glitch_at);
    int lat     = -1;
    bit overlap = 1'b0;
    bit busy_ok = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      start = (n == glitch_at);
      if (n == glitch_at) begin
        op = ~v.op;
        a  = 32'h0000_0003;
        b  = 32'h0000_0005;
      end
      if (busy && done) overlap = 1'b1;
      if (n <= 32 && !busy) busy_ok = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check({v.name, " latency"},  64'(lat),     64'd33);
    check({v.name, " busy_run"}, 64'(busy_ok), 64'd1);
    check({v.name, " overlap"},  64'(overlap), 64'd0);
    check({v.name, " HI"},       64'(hi),      64'(v.hi));
    check({v.name, " LO"},       64'(lo),      64'(v.lo));
    check({v.name, " div_zero"}, 64'(dz),      64'(v.dz));
  endtask

  task automatic run_vec(input vec_t v, input int glitch_at);
    @(negedge clk);
    launch(v.op, v.sign, v.a, v.b);
    collect(v, glitch_at);
    @(posedge clk);
    #1;
    check({v.name, " done_pulse"}, 64'({done, busy}), 64'd0);
  endtask

  vec_t vecs[12];
  vec_t v_a;
  vec_t v_b;
  bit   saw_done;

  initial begin
    vecs = '{
      '{"mulu_max",    MD_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
      '{"muls_m3x7",   MD_MUL, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0},
      '{"mulu_x16",    MD_MUL, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0},
      '{"muls_min2",   MD_MUL, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0},
      '{"muls_m1m1",   MD_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0},
      '{"divs_m7d2",   MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0},
      '{"divs_7dm2",   MD_DIV, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0},
      '{"divu_zero",   MD_DIV, 1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1},
      '{"divu_100d7",  MD_DIV, 1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0},
      '{"divs_ovf",    MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0},
      '{"divu_5dmax",  MD_DIV, 1'b0, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0005, 32'h0000_0000, 1'b0},
      '{"divs_zeroneg", MD_DIV, 1'b1, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1}
    };

    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    sign  = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("reset_state", {busy, done, dz, hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_idle", {busy, done, dz, hi, lo}, 64'd0);

    foreach (vecs[i]) run_vec(vecs[i], 0);

    // Reset at iteration 10: outputs return to zero without waiting for an edge.
    @(negedge clk);
    launch(MD_MUL, 1'b0, 32'h0000_0003, 32'h0000_0005);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midreset_outputs", {busy, done, dz, hi, lo}, 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("midreset_no_done", 64'(saw_done), 64'd0);

    // start pulsed at iteration 5 while busy: ignored, result unaffected.
    v_a = '{"glitch_100d7", MD_DIV, 1'b0, 32'h0000_0064, 32'h0000_0007,
            32'h0000_0002, 32'h0000_000E, 1'b0};
    run_vec(v_a, 5);

    // Back-to-back: second start issued in the done cycle.
    v_a = '{"b2b_first",  MD_DIV, 1'b0, 32'h0000_0000, 32'h0000_0000,
            32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
    v_b = '{"b2b_second", MD_MUL, 1'b1, 32'h0000_0006, 32'hFFFF_FFF9,
            32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0};
    @(negedge clk);
    launch(v_a.op, v_a.sign, v_a.a, v_a.b);
    collect(v_a, 0);
    check("b2b_done_high", 64'(done), 64'd1);
    launch(v_b.op, v_b.sign, v_b.a, v_b.b);
    collect(v_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
